// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative cipher.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned BLK_BITS = 128;

  // Round constants indexed by schedule step (entry 0 and 11..15 unused).
  localparam logic [7:0] RCON_TBL [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Number of rounds for a given key length.
  function automatic int unsigned aes_nr(input int unsigned key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // MixColumns on one column, byte 0 in the MSBs.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout_c
);

  logic [7:0] sq;
  logic [7:0] inv;

  // din^254 (the inverse, 0 maps to 0) as the product of din^2 .. din^128, then affine.
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    dout_c = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryptor, one round per clock, key schedule expanded on the fly.
// Optional macro AES_ITER_PERF_EN adds the blk_count completed-block counter.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic [127:0]        text_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        text_out
`ifdef AES_ITER_PERF_EN
  ,
  output logic [31:0]         blk_count
`endif
);

  localparam int unsigned NR = aes_nr(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_cipher: KEY_BITS must be 128 or 256");
  end

  state_t              state, state_nxt;
  logic [3:0]          rnd;
  logic                accept, last;
  logic [127:0]        st, sb, sr, mc, rk, round_out;
  logic [KEY_BITS-1:0] kreg, kreg_nxt;
  logic [31:0]         w_last, sw_in, sw_out;
  logic [31:0]         n0, n1, n2, n3;
  logic [7:0]          rcon;
  logic [127:0]        old4;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake decode; HOLD refills in the same cycle it drains.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = (state == RUN) && (rnd == 4'(NR));
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          in_ready  = 1'b1;
          accept    = in_valid;
          state_nxt = in_valid ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SubBytes on the whole state.
  for (genvar b = 0; b < 16; b++) begin : g_subbytes
    aes_sbox u_sbox (.din(st[127-8*b -: 8]), .dout_c(sb[127-8*b -: 8]));
  end

  // ShiftRows then MixColumns; the last round bypasses MixColumns.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    round_out = (last ? sr : mc) ^ rk;
  end

  // SubWord for the key schedule.
  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (.din(sw_in[31-8*i -: 8]), .dout_c(sw_out[31-8*i -: 8]));
  end

  assign w_last = kreg[31:0];

  if (KEY_BITS == 256) begin : g_ks256
    // Window holds w[4r-4..4r+3]; this round uses its low half and generates w[4r+4..4r+7].
    // Odd rounds start a new 8-word group (RotWord + Rcon), even rounds only SubWord.
    always_comb begin
      sw_in    = rnd[0] ? {w_last[23:0], w_last[31:24]} : w_last;
      rcon     = rnd[0] ? RCON_TBL[4'(rnd + 4'd1) >> 1] : 8'h00;
      old4     = kreg[KEY_BITS-1 -: 128];
      rk       = kreg[127:0];
      kreg_nxt = {kreg[127:0], n0, n1, n2, n3};
    end
  end else begin : g_ks128
    // kreg holds the previous round key; this round's key is derived combinationally.
    always_comb begin
      sw_in    = {w_last[23:0], w_last[31:24]};
      rcon     = RCON_TBL[rnd];
      old4     = kreg[127:0];
      rk       = {n0, n1, n2, n3};
      kreg_nxt = {n0, n1, n2, n3};
    end
  end

  // Four new schedule words from the word window.
  always_comb begin
    n0 = old4[127:96] ^ sw_out ^ {rcon, 24'h000000};
    n1 = old4[95:64]  ^ n0;
    n2 = old4[63:32]  ^ n1;
    n3 = old4[31:0]   ^ n2;
  end

  // Datapath, round counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= '0;
      kreg      <= '0;
      rnd       <= 4'd0;
      out_valid <= 1'b0;
      text_out  <= '0;
    end else begin
      if (accept) begin
        st   <= text_in ^ key[KEY_BITS-1 -: 128];
        kreg <= key;
        rnd  <= 4'd1;
      end else if (state == RUN) begin
        st   <= round_out;
        kreg <= kreg_nxt;
        rnd  <= last ? 4'd0 : rnd + 4'd1;
      end
      if (last) begin
        out_valid <= 1'b1;
        text_out  <= round_out;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef AES_ITER_PERF_EN
  // Completed-block counter, bumps with each out_valid rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       blk_count <= 32'd0;
    else if (last) blk_count <= blk_count + 32'd1;
  end
`endif

endmodule

// File: doc/aes_iter_cipher.md
AES_ITER_CIPHER -- requirements
Module: aes_iter_cipher

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, meaning cipher key length; legal values 128 and 256 only, any other value SHALL fail elaboration.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  key/text_in presented.
REQ-005 SHALL have port in_ready  output  1  block can accept a new block this cycle.
REQ-006 SHALL have port key  input  KEY_BITS  cipher key, MSB = first key byte, sampled only on accept.
REQ-007 SHALL have port text_in  input  128  plaintext block, MSB = byte 0, sampled only on accept.
REQ-008 SHALL have port out_valid  output  1  text_out holds a finished ciphertext.
REQ-009 SHALL have port out_ready  input  1  consumer takes text_out this cycle.
REQ-010 SHALL have port text_out  output  128  ciphertext, FIPS-197 byte order.

Function
REQ-011 SHALL implement FIPS-197 AES encryption, Nr = 10 (KEY_BITS=128) or 14 (KEY_BITS=256), one round per clock, round keys expanded on the fly.
REQ-012 SHALL use states IDLE, RUN, HOLD; IDLE->RUN on accept; RUN->HOLD after round Nr; HOLD->IDLE on out_ready without in_valid; HOLD->RUN on out_ready with in_valid.
REQ-013 SHALL define accept as rising edge with in_valid & in_ready; at accept, state register = text_in XOR key[KEY_BITS-1:KEY_BITS-128], round counter = 1.
REQ-014 SHALL assert in_ready in IDLE, and in HOLD only while out_ready is high (same-cycle drain and refill); in_ready SHALL be low in RUN.
REQ-015 SHALL raise out_valid exactly Nr rising edges after the accepting edge (10 or 14), with final round omitting MixColumns.
REQ-016 SHALL hold text_out and out_valid stable while out_valid & !out_ready; out_valid SHALL drop on the edge where out_ready is high unless a new block is accepted the same edge, in which case out_valid drops and the new block starts.
REQ-017 SHALL ignore key/text_in changes in RUN and HOLD.
REQ-018 SHALL compute KEY_BITS=256 expansion with the extra SubWord step for every w[i], i mod 8 = 4, and Rcon only when i mod 8 = 0.
REQ-019 SHALL treat out_ready high with out_valid low as no-op.

Reset
REQ-020 SHALL on rst high immediately force state IDLE, out_valid 0, in_ready 1 (after rst release), text_out 0, round counter 0, independent of clk.
REQ-021 SHALL abandon an in-flight block when rst asserts mid-RUN; no partial result SHALL ever appear with out_valid high.
REQ-022 SHALL accept a block on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, with macro AES_ITER_PERF_EN defined, add output blk_count (32 bits) counting completed blocks (incremented on each out_valid rising, wraps 0xFFFFFFFF->0, reset to 0).
REQ-024 SHALL, without AES_ITER_PERF_EN, omit blk_count port and its logic entirely; all other behaviour identical.

Structure
REQ-025 SHALL place in shared package aes_pkg: state enum type, Nr function of KEY_BITS, Rcon table, xtime/GF(2^8) multiply function.
REQ-026 SHALL instantiate sub-module aes_sbox (8-bit combinational S-box) 16 times for SubBytes and 4 times for SubWord; no other sub-modules.

Verification
REQ-027 SHALL cover KEY_BITS=128, key 0, text_in 0 -> text_out 66e94bd4ef8a2c3b884cfa59ca342b2e, out_valid 10 edges after accept.
REQ-028 SHALL cover back-to-back: key 0, text_in 66e94bd4ef8a2c3b884cfa59ca342b2e accepted in HOLD with out_ready high -> second text_out f795bd4a52e29ed713d313fa20e98dbc, no bubble cycle.
REQ-029 SHALL cover KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, text_in 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-030 SHALL cover KEY_BITS=256, key 000102...1e1f, same text_in -> 8ea2b7ca516745bfeafc49904b496089, out_valid 14 edges after accept.
REQ-031 SHALL cover backpressure: out_ready low 5 cycles after out_valid -> text_out stable, in_ready low; then rst pulse mid-RUN -> out_valid 0 immediately, next accept gives correct result.
REQ-032 SHALL cover AES_ITER_PERF_EN: three completed blocks -> blk_count = 3; rst -> 0.
